keyed_lock_unit: RTL
====================

# keyed_lock_unit

Parametrised, sequential successor to the team's fixed mux4/XOR key-gate locking: holds the key in on-chip registers loaded over a serial port, then applies it to a registered datapath. The datapath has XOR key gates on the low input bits and mux4 (2-input LUT) key gates on input bit pairs. Sits between the primary inputs and the locked core in a locked-netlist experiment; the core consumes `data_out`/`lut_out`.

## Interface
- `DATA_W`, 36: data path width.
- `XOR_N`, 11: number of XOR key gates, applied to `data_in[XOR_N-1:0]`; must satisfy `XOR_N <= DATA_W`.
- `MUX_N`, 8: number of mux4 key gates; must satisfy `2*MUX_N <= DATA_W`.
- `KEY_W`, derived, `XOR_N + 4*MUX_N` (43 at defaults): key length.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `key_sin` in 1: serial key bit.
- `key_sen` in 1: shift enable.
- `key_commit` in 1: one-cycle request to activate the shadow key.
- `key_sout` out 1: serial readback (see Configuration).
- `key_armed` out 1: an active key is present.
- `key_err` out 1: one-cycle pulse when a commit is rejected.
- `in_valid` in 1: `data_in` is valid this cycle.
- `data_in` in DATA_W: primary inputs.
- `out_valid` out 1: `data_out`/`lut_out` are valid.
- `data_out` out DATA_W: `data_in` with XOR key applied.
- `lut_out` out MUX_N: mux4 key-gate outputs.

## Operation
- **Shadow register** `shadow[KEY_W-1:0]`. On a `key_sen` cycle without commit: `shadow <= {shadow[KEY_W-2:0], key_sin}`. The first bit shifted ends at the MSB.
- **Shift counter** `cnt`, width `$clog2(KEY_W+2)`:
  - increments per shift;
  - saturates at `KEY_W+1` (overlength marker);
  - cleared on reset and on every commit, accepted or rejected.
- **Key field mapping** (same for shadow and active key):
  - `key[XOR_N-1:0]` is the XOR key;
  - `key[XOR_N+4i +: 4]` is the LUT for mux gate i.
- **FSM states:**
  - UNKEYED: reset state.
  - LOAD: shifting, no active key.
  - ARMED: active key valid.
  - RELOAD: shifting while the old active key stays in use.
- **Transitions:**
  - UNKEYED→LOAD and ARMED→RELOAD on `key_sen`. That cycle's bit counts, so `cnt=1`.
  - LOAD/RELOAD on `key_commit` with `cnt==KEY_W`: `active <= shadow`, go to ARMED.
  - LOAD on `key_commit` with `cnt!=KEY_W`: pulse `key_err`, go to UNKEYED.
  - RELOAD on `key_commit` with `cnt!=KEY_W`: pulse `key_err`, return to ARMED with the old key kept.
  - Commit in UNKEYED or ARMED (no shifting since the last commit): rejected, `key_err`, state unchanged.
- **Simultaneous `key_sen` and `key_commit`:** commit wins; that cycle's shift is ignored.
- **Datapath**, registered, one stage:
  - `data_out <= data_in ^ {{(DATA_W-XOR_N){1'b0}}, active[XOR_N-1:0]}`.
  - `lut_out[i] <= active[XOR_N+4i + {data_in[2i+1], data_in[2i]}]`.
  - Registers load only when `in_valid` is high and the state is ARMED or RELOAD; otherwise they hold.
- **`out_valid`** `<= in_valid & (state is ARMED or RELOAD)`.
- **`key_armed`** = state is ARMED or RELOAD.

## Timing
- Reset values:
  - state UNKEYED; `shadow`, `active`, `cnt` = 0;
  - `data_out=0`, `lut_out=0`, `out_valid=0`, `key_err=0`, `key_sout=0`.
- Reset asserted mid-load or mid-operation clears everything immediately (asynchronous). The old key is lost.
- Datapath latency: 1 cycle, `in_valid` at edge n gives `out_valid` after edge n+1. Full throughput, no backpressure.
- Key activation: a commit at edge n gives `key_armed` and new-key outputs for `in_valid` sampled at edge n+1 onward.
- `key_err` is high for exactly the one cycle following the rejected commit edge.

## Configuration
- **`KEY_LOCK_READBACK_EN` defined:** `key_sout = shadow[KEY_W-1]`, registered (it is a register bit). Shifting KEY_W bits through therefore returns the previous shadow contents MSB-first. The active key is never readable.
- **Not defined:** `key_sout` is tied to 0 and no readback logic is synthesised.

## Test plan
- Defaults. Shift 43 bits giving `shadow = 43'h7FF_0000_0AAA`-pattern (XOR key `11'h2AA`), then commit. Drive `data_in=0`, `in_valid=1` → one cycle later `out_valid=1`, `data_out=36'h0_0000_02AA`, `key_armed=1`.
- LUT key `4'b0110` (XOR function) in all 8 mux fields. Sweep all pairs `data_in[1:0]` 00/01/10/11 → `lut_out[0]` = 0/1/1/0.
- Shift 42 bits then commit → `key_err` one-cycle pulse, state UNKEYED, `out_valid` stays 0. Repeat with 50 bits → same result (saturation).
- ARMED with key A. Reload 20 bits then commit → `key_err`, outputs still computed with key A. Full 43-bit reload with key B then commit → outputs switch to key B on the next valid.
- Assert `rst` mid-shift at bit 30 and while ARMED → all outputs 0 immediately, `key_armed=0`. After release, an `in_valid` pulse gives `out_valid=0`.
- With `KEY_LOCK_READBACK_EN`: load key A, then shift 43 new bits → `key_sout` reproduces A MSB-first. Without the macro → `key_sout` constant 0.

Source files
------------

// File: rtl/keyed_lock_unit.sv
// keyed_lock_unit: serially loaded key registers driving XOR and mux4 key gates.
// Optional serial readback of the shadow register: define KEY_LOCK_READBACK_EN.
`timescale 1ns/1ps

module keyed_lock_unit #(
    parameter int DATA_W = 36,
    parameter int XOR_N  = 11,
    parameter int MUX_N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_sin,
    input  logic              key_sen,
    input  logic              key_commit,
    output logic              key_sout,
    output logic              key_armed,
    output logic              key_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [MUX_N-1:0]  lut_out
);

    localparam int KEY_W = XOR_N + 4 * MUX_N;
    localparam int CNT_W = $clog2(KEY_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(KEY_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_UNKEYED = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_ARMED   = 2'd2;
    localparam logic [1:0] S_RELOAD  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [KEY_W-1:0]  shadow;
    logic [KEY_W-1:0]  shadow_nxt;
    logic [KEY_W-1:0]  active;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              active_ld;
    logic              err_nxt;
    logic              len_ok;
    logic              live;
    logic [DATA_W-1:0] xor_mask;
    logic [MUX_N-1:0]  lut_nxt;
    logic [1:0]        lut_sel;
    logic [3:0]        lut_nib;

    assign live      = (state == S_ARMED) || (state == S_RELOAD);
    assign key_armed = live;
    assign len_ok    = (cnt == CNT_FULL);

    // Key-load control: commit has priority over a same-cycle shift.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        active_ld  = 1'b0;
        err_nxt    = 1'b0;
        if (key_commit) begin
            cnt_nxt = '0;
            unique case (state)
                S_LOAD: begin
                    if (len_ok) begin
                        active_ld = 1'b1;
                        state_nxt = S_ARMED;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_UNKEYED;
                    end
                end
                S_RELOAD: begin
                    state_nxt = S_ARMED;
                    if (len_ok) begin
                        active_ld = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    err_nxt = 1'b1;
                end
            endcase
        end else if (key_sen) begin
            shadow_nxt = {shadow[KEY_W-2:0], key_sin};
            if (cnt != CNT_SAT) begin
                cnt_nxt = cnt + CNT_ONE;
            end
            if (state == S_UNKEYED) begin
                state_nxt = S_LOAD;
            end else if (state == S_ARMED) begin
                state_nxt = S_RELOAD;
            end
        end
    end

    // Control state, shift register, bit counter and reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_UNKEYED;
            shadow  <= '0;
            cnt     <= '0;
            key_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            cnt     <= cnt_nxt;
            key_err <= err_nxt;
        end
    end

    // Active key only changes on an accepted full-length commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (active_ld) begin
            active <= shadow;
        end
    end

    // XOR key covers only the low XOR_N data bits.
    always_comb begin
        xor_mask              = '0;
        xor_mask[XOR_N-1:0]   = active[XOR_N-1:0];
    end

    // Each mux4 gate looks up its 4-bit LUT with one data bit pair.
    always_comb begin
        lut_nxt = '0;
        lut_sel = '0;
        lut_nib = '0;
        for (int i = 0; i < MUX_N; i++) begin
            lut_sel    = {data_in[2*i+1], data_in[2*i]};
            lut_nib    = active[XOR_N+4*i +: 4];
            lut_nxt[i] = lut_nib[lut_sel];
        end
    end

    // One-stage datapath; holds unless a valid input arrives with a key live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            lut_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid & live;
            if (in_valid && live) begin
                data_out <= data_in ^ xor_mask;
                lut_out  <= lut_nxt;
            end
        end
    end

`ifdef KEY_LOCK_READBACK_EN
    // Readback taps the shadow MSB, so it is already a register output.
    assign key_sout = shadow[KEY_W-1];
`else
    assign key_sout = 1'b0;
`endif

endmodule
